// File: rtl/cmd_ctrl_pkg.sv
// rtl/cmd_ctrl_pkg.sv - shared opcodes, FSM states and status bit positions for cmd_ctrl
package cmd_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ACC   = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_CLR   = 3'd4;

  localparam int ST_TIMEOUT = 0;
  localparam int ST_ILLEGAL = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVERRUN = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    RD_SETUP,
    RD_SEND,
    RD_WAIT
  } state_t;

  // Opcodes above OP_CLR carry no meaning and are rejected at dispatch.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_CLR;
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - saturating inter-byte cycle counter with expiry flag
module cmd_timeout #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count;

  // Count idle cycles; clr restarts the window, the count holds once it hits TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != TO_W'(TIMEOUT))) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = (count == TO_W'(TIMEOUT));

endmodule

// File: rtl/cmd_ctrl.sv
// rtl/cmd_ctrl.sv - host command framer, array dispatcher and readback streamer
module cmd_ctrl
  import cmd_ctrl_pkg::*;
#(
  parameter int  DATA_BYTES = 4,
  parameter int  N_SEL      = 16,
  parameter int  TIMEOUT    = 1000,
  localparam int DW         = 8 * DATA_BYTES,
  localparam int SEL_W      = (N_SEL > 1) ? $clog2(N_SEL) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_send,
  output logic [7:0]       tx_data,
  output logic [7:0]       cmd_addr,
  output logic [DW-1:0]    cmd_data,
  output logic             wr,
  output logic             acc,
  output logic             clear,
  output logic [SEL_W-1:0] sel,
  input  logic [DW-1:0]    rd_data,
  output logic [7:0]       status
);

  localparam int CNT_W    = $clog2(DATA_BYTES + 2) + 1;
  localparam int IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int LAST_IDX = DATA_BYTES - 1;

  localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SEL - 1);

  state_t           state, state_n;
  logic [2:0]       op;
  logic [CNT_W-1:0] byte_cnt;
  logic [IDX_W-1:0] idx;
  logic             first_wait;
  logic [3:0]       frame_cnt;
  logic             timeout_flag, illegal_flag, overrun_flag;
  logic             to_expired;
  logic             wait_done;
  logic [7:0]       cur_byte;

  cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state != LOAD) || rx_valid),
    .en      (state == LOAD),
    .expired (to_expired)
  );

  // A byte arriving in the same cycle as expiry keeps the frame alive.
  assign wait_done = !first_wait && !tx_busy;
  assign cur_byte  = rd_data[8 * (LAST_IDX - int'(idx)) +: 8];
  assign status    = {frame_cnt, overrun_flag, (state != IDLE), illegal_flag, timeout_flag};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and strobe decode; strobes only come from single states so they never overlap.
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    acc     = 1'b0;
    clear   = 1'b0;
    tx_send = 1'b0;
    tx_data = 8'h00;
    case (state)
      IDLE: begin
        if (rx_valid) state_n = LOAD;
      end
      LOAD: begin
        if (rx_valid) begin
          if (byte_cnt == LAST_CNT) state_n = EXEC;
        end else if (to_expired) begin
          state_n = IDLE;
        end
      end
      EXEC: begin
        case (op)
          OP_WRITE: wr    = 1'b1;
          OP_ACC:   acc   = 1'b1;
          OP_CLR:   clear = 1'b1;
          default:  ;
        endcase
        state_n = (op == OP_READ) ? RD_SETUP : IDLE;
      end
      RD_SETUP: begin
        state_n = RD_SEND;
      end
      RD_SEND: begin
        if (!tx_busy) begin
          tx_send = 1'b1;
          tx_data = cur_byte;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_done) begin
          if (int'(idx) != LAST_IDX) state_n = RD_SEND;
          else if (sel == LAST_SEL)  state_n = IDLE;
          else                       state_n = RD_SETUP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame capture, readback indices and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op           <= OP_NOP;
      byte_cnt     <= '0;
      cmd_addr     <= 8'h00;
      cmd_data     <= '0;
      sel          <= '0;
      idx          <= '0;
      first_wait   <= 1'b0;
      frame_cnt    <= 4'h0;
      timeout_flag <= 1'b0;
      illegal_flag <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      first_wait <= (state == RD_SEND) && !tx_busy;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            op       <= rx_data[2:0];
            byte_cnt <= ADDR_CNT;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == ADDR_CNT) cmd_addr <= rx_data;
            else                      cmd_data <= (cmd_data << 8) | DW'(rx_data);
          end else if (to_expired) begin
            timeout_flag <= 1'b1;
          end
        end
        EXEC: begin
          if (op == OP_READ) sel <= '0;
          if (op_legal(op)) frame_cnt    <= frame_cnt + 4'd1;
          else              illegal_flag <= 1'b1;
          if (op == OP_CLR) begin
            timeout_flag <= 1'b0;
            illegal_flag <= 1'b0;
            overrun_flag <= 1'b0;
          end
        end
        RD_SETUP: begin
          idx <= '0;
        end
        RD_WAIT: begin
          if (wait_done) begin
            if (int'(idx) != LAST_IDX) idx <= idx + IDX_W'(1);
            else if (sel != LAST_SEL)  sel <= sel + SEL_W'(1);
          end
        end
        default: ;
      endcase
      // Frames are never queued: any byte outside IDLE/LOAD is lost and flagged.
      if (rx_valid && (state != IDLE) && (state != LOAD)) overrun_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_ctrl.sv
// tb/tb_cmd_ctrl.sv - scoreboard bench for cmd_ctrl
module tb_cmd_ctrl;

  localparam int DB = 4;
  localparam int NS = 2;
  localparam int TO = 20;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_busy;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic [7:0]    cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          wr, acc, clear;
  logic [0:0]    sel;
  logic [DW-1:0] rd_data = '0;
  logic [7:0]    status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int busy_cnt = 0;

  cmd_ctrl #(
    .DATA_BYTES (DB),
    .N_SEL      (NS),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .wr       (wr),
    .acc      (acc),
    .clear    (clear),
    .sel      (sel),
    .rd_data  (rd_data),
    .status   (status)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after tx_send for three cycles.
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Array model: word at sel is {sel, 00, 11, 22}, registered.
  always @(posedge clk) rd_data <= {7'b0, sel, 8'h00, 8'h11, 8'h22};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      int kind;
      exp_t e;
      n = int'(wr) + int'(acc) + int'(clear) + int'(tx_send);
      if (n > 1) chk("strobe_exclusive", 32'(n), 32'd1);
      if (n != 0) begin
        kind = wr ? 1 : acc ? 2 : clear ? 3 : 4;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(kind), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(kind), 32'(e.kind));
          if (kind == 4) begin
            chk("tx_byte", 32'(tx_data), e.data);
            chk("tx_while_idle", 32'(tx_busy), 32'd0);
          end else begin
            chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
            chk("cmd_data", cmd_data, e.data);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] addr, input logic [31:0] data);
    send_byte(hdr);
    send_byte(addr);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
  endtask

  // Frame with a strobe: queue it, then the strobe must be present in the following cycle.
  task automatic strobe_frame(input int kind, input logic [7:0] hdr, input logic [7:0] addr,
                              input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
    send_frame(hdr, addr, data);
    @(negedge clk);
    chk("strobe_latency", {29'd0, clear, acc, wr}, 32'(1 << (kind - 1)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (status[2] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'(status[2]), 32'd0);
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_t e;
    e.kind = 4; e.addr = 8'h00; e.data = 32'(b);
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_status", 32'(status), 32'h00);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_cmd_data", cmd_data, 32'd0);

    // WRITE
    strobe_frame(1, 8'h01, 8'h05, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("write_status", 32'(status), 32'h10);
    chk("write_addr", 32'(cmd_addr), 32'h05);

    // ACC then CLR; header bits [7:3] must be ignored on the CLR
    strobe_frame(2, 8'h02, 8'h00, 32'h00000007);
    repeat (2) @(negedge clk);
    chk("acc_status", 32'(status), 32'h20);
    strobe_frame(3, 8'hF4, 8'h00, 32'h00000000);
    repeat (2) @(negedge clk);
    chk("clr_status", 32'(status), 32'h30);

    // Timeout after header+address, then a clean frame
    send_byte(8'h01);
    send_byte(8'h05);
    repeat (15) @(negedge clk);
    chk("timeout_not_yet", 32'(status[0]), 32'd0);
    repeat (10) @(negedge clk);
    chk("timeout_flag", 32'(status[0]), 32'd1);
    chk("timeout_idle", 32'(status[2]), 32'd0);
    strobe_frame(1, 8'h01, 8'hAA, 32'h01020304);
    repeat (2) @(negedge clk);
    chk("post_timeout_status", 32'(status), 32'h41);

    // Illegal opcode: no strobe, count unchanged
    send_frame(8'h07, 8'h12, 32'h11223344);
    repeat (3) @(negedge clk);
    chk("illegal_status", 32'(status), 32'h43);

    // CLR drops the sticky bits
    strobe_frame(3, 8'h04, 8'h00, 32'h00000000);
    repeat (2) @(negedge clk);
    chk("clr2_status", 32'(status), 32'h50);

    // READ with an overrun byte mid-stream
    push_tx(8'h00); push_tx(8'h00); push_tx(8'h11); push_tx(8'h22);
    push_tx(8'h01); push_tx(8'h00); push_tx(8'h11); push_tx(8'h22);
    send_frame(8'h03, 8'h00, 32'h00000000);
    repeat (6) @(negedge clk);
    send_byte(8'h55);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("read_sel_end", 32'(sel), 32'd1);
    chk("read_status", 32'(status), 32'h68);
    chk("read_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a second readback
    push_tx(8'h00); push_tx(8'h00); push_tx(8'h11); push_tx(8'h22);
    push_tx(8'h01); push_tx(8'h00); push_tx(8'h11); push_tx(8'h22);
    send_frame(8'h03, 8'h00, 32'h00000000);
    repeat (12) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_strobes", {28'd0, tx_send, clear, acc, wr}, 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    chk("rst_status", 32'(status), 32'h00);
    repeat (20) @(negedge clk);
    chk("rst_quiet", 32'(status), 32'h00);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
